cdac_serial_rx: RTL and testbench

//  Receive end of the comparator-threshold DAC serial load link (SCLK/SDATA/DAC_ENB).

---
 rtl/cdac_serial_rx.sv | 152 +++++++++++++++
 tb/tb_cdac_serial_rx.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/cdac_serial_rx.sv
// Receive end of the comparator-threshold DAC serial link: oversampled in CLK40, 16-bit MSB-first frames.
// Optional idle timeout in SHIFT enabled by defining CDAC_RX_TIMEOUT_EN.
module cdac_serial_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        CLK40,
  input  logic        RST_N,
  input  logic        SCLK,
  input  logic        SDATA,
  input  logic        DAC_ENB,
  input  logic        CLR_RX_DONE,
  output logic [11:0] RX_DATA,
  output logic        RX_VALID,
  output logic        RX_DONE,
  output logic        FRAME_ERR,
  output logic [1:0]  RX_STATE
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_param_chk
    $error("cdac_serial_rx: illegal SYNC_STAGES or TIMEOUT_CYC");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10,
    ABORT = 2'b11
  } state_e;

  logic [SYNC_STAGES-1:0] sclk_sync_q, sdata_sync_q, enb_sync_q;
  logic                   sclk_prev_q, enb_prev_q;
  logic                   sclk_s, sdata_s, enb_s;
  logic                   sclk_re, enb_re, enb_fe;

  // Enable chain resets high so a DAC_ENB already high out of reset is not seen as a rising edge.
  always_ff @(posedge CLK40 or negedge RST_N) begin
    if (!RST_N) begin
      sclk_sync_q  <= '0;
      sdata_sync_q <= '0;
      enb_sync_q   <= '1;
      sclk_prev_q  <= 1'b0;
      enb_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q  <= {sclk_sync_q[SYNC_STAGES-2:0], SCLK};
      sdata_sync_q <= {sdata_sync_q[SYNC_STAGES-2:0], SDATA};
      enb_sync_q   <= {enb_sync_q[SYNC_STAGES-2:0], DAC_ENB};
      sclk_prev_q  <= sclk_s;
      enb_prev_q   <= enb_s;
    end
  end

  assign sclk_s  = sclk_sync_q[SYNC_STAGES-1];
  assign sdata_s = sdata_sync_q[SYNC_STAGES-1];
  assign enb_s   = enb_sync_q[SYNC_STAGES-1];
  assign sclk_re = sclk_s & ~sclk_prev_q;
  assign enb_re  = enb_s & ~enb_prev_q;
  assign enb_fe  = ~enb_s & enb_prev_q;

  state_e      state_q;
  logic [15:0] sr_q, sr_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [11:0] data_q;
  logic        valid_q, done_q, ferr_q;
  logic        frame_good;

  // Shift result for this cycle, so an enb_fe coinciding with the last sclk_re sees the final bit.
  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (sclk_re) begin
      if (cnt_q < 5'd16) sr_d = {sr_q[14:0], sdata_s};
      if (cnt_q != 5'd17) cnt_d = cnt_q + 5'd1;
    end
  end

  assign frame_good = (cnt_d == 5'd16) && (sr_d[15:13] == 3'b000) && !sr_d[0];

`ifdef CDAC_RX_TIMEOUT_EN
  localparam logic [7:0] TO_LIM = 8'(TIMEOUT_CYC);
  logic [7:0] idle_q;
`endif

  always_ff @(posedge CLK40 or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef CDAC_RX_TIMEOUT_EN
      idle_q  <= '0;
`endif
    end else begin
      valid_q <= 1'b0;
      if (CLR_RX_DONE) begin
        done_q <= 1'b0;
        ferr_q <= 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          if (enb_re) begin
            state_q <= SHIFT;
            sr_q    <= '0;
            cnt_q   <= '0;
`ifdef CDAC_RX_TIMEOUT_EN
            idle_q  <= '0;
`endif
          end
        end
        SHIFT: begin
          sr_q  <= sr_d;
          cnt_q <= cnt_d;
          if (enb_fe) begin
            if (frame_good) begin
              state_q <= DONE;
              data_q  <= sr_d[12:1];
              valid_q <= 1'b1;
            end else begin
              state_q <= ABORT;
            end
          end
`ifdef CDAC_RX_TIMEOUT_EN
          else if (sclk_re) idle_q <= '0;
          else if (idle_q == TO_LIM) state_q <= ABORT;
          else idle_q <= idle_q + 8'd1;
`endif
        end
        // Flag sets come after the clear above, so a coincident set wins.
        DONE: begin
          done_q  <= 1'b1;
          ferr_q  <= 1'b0;
          state_q <= IDLE;
        end
        ABORT: begin
          ferr_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign RX_DATA   = data_q;
  assign RX_VALID  = valid_q;
  assign RX_DONE   = done_q;
  assign FRAME_ERR = ferr_q;
  assign RX_STATE  = state_q;

endmodule

// File: tb/tb_cdac_serial_rx.sv
// Scoreboard bench for cdac_serial_rx: directed frames push expected events, a monitor pops on RX_VALID / ABORT.
`timescale 1ns/1ps
module tb_cdac_serial_rx;

  localparam time HALF_SCLK = 500ns;

  logic        CLK40 = 1'b0;
  logic        RST_N = 1'b0;
  logic        SCLK = 1'b0, SDATA = 1'b0, DAC_ENB = 1'b0, CLR_RX_DONE = 1'b0;
  logic [11:0] RX_DATA;
  logic        RX_VALID, RX_DONE, FRAME_ERR;
  logic [1:0]  RX_STATE;

  cdac_serial_rx #(.SYNC_STAGES(2), .TIMEOUT_CYC(255)) dut (
    .CLK40(CLK40), .RST_N(RST_N), .SCLK(SCLK), .SDATA(SDATA), .DAC_ENB(DAC_ENB),
    .CLR_RX_DONE(CLR_RX_DONE), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID),
    .RX_DONE(RX_DONE), .FRAME_ERR(FRAME_ERR), .RX_STATE(RX_STATE)
  );

  always #12.5ns CLK40 = ~CLK40;

  typedef struct {
    bit          is_err;
    logic [11:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, exp);
  endtask

  always @(negedge CLK40) begin
    if (RST_N === 1'b1 && (RX_VALID === 1'b1 || RX_STATE === 2'b11)) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_event: valid=%b state=%b data=%h, required no event",
                 RX_VALID, RX_STATE, RX_DATA);
      end else begin
        automatic ev_t e = exp_q.pop_front();
        if (e.is_err) begin
          check("abort_state", 32'(RX_STATE), 32'd3);
        end else begin
          check("valid_state", 32'(RX_STATE), 32'd2);
          check("valid_data", 32'(RX_DATA), 32'(e.data));
        end
      end
    end
  end

  task automatic push(input bit is_err, input logic [11:0] data);
    ev_t e;
    e.is_err = is_err;
    e.data   = data;
    exp_q.push_back(e);
  endtask

  task automatic send_bits(input logic [16:0] w, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      SDATA = w[i];
      #HALF_SCLK SCLK = 1'b1;
      #HALF_SCLK SCLK = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 100) begin
      @(posedge CLK40);
      k++;
    end
    check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    repeat (5) @(posedge CLK40);
  endtask

  task automatic frame(input logic [16:0] w, input int n, input bit is_err, input logic [11:0] code);
    push(is_err, code);
    DAC_ENB = 1'b1;
    repeat (10) @(posedge CLK40);
    send_bits(w, n);
    #200ns DAC_ENB = 1'b0;
    wait_drain();
  endtask

  task automatic check_flags(input string tag, input logic [11:0] data, input bit done, input bit ferr);
    #1;
    check({tag, "_data"}, 32'(RX_DATA), 32'(data));
    check({tag, "_done"}, 32'(RX_DONE), 32'(done));
    check({tag, "_ferr"}, 32'(FRAME_ERR), 32'(ferr));
  endtask

  task automatic check_reset_outputs(input string tag);
    #1;
    check({tag, "_data"}, 32'(RX_DATA), 32'd0);
    check({tag, "_valid"}, 32'(RX_VALID), 32'd0);
    check({tag, "_done"}, 32'(RX_DONE), 32'd0);
    check({tag, "_ferr"}, 32'(FRAME_ERR), 32'd0);
    check({tag, "_state"}, 32'(RX_STATE), 32'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit clr_seen;
    repeat (3) @(posedge CLK40);
    check_reset_outputs("reset");
    @(negedge CLK40) RST_N = 1'b1;
    repeat (10) @(posedge CLK40);

    // code 12'hABC -> stream 16'h1578
    frame(17'h01578, 16, 1'b0, 12'hABC);
    check_flags("t1", 12'hABC, 1'b1, 1'b0);

    // short then long frame
    frame(17'h00ABC, 15, 1'b1, 12'h000);
    check_flags("t2_short", 12'hABC, 1'b1, 1'b1);
    frame(17'h02AF0, 17, 1'b1, 12'h000);
    check_flags("t2_long", 12'hABC, 1'b1, 1'b1);

    // framing-bit violations
    frame(17'h08002, 16, 1'b1, 12'h000);
    check_flags("t3_lead", 12'hABC, 1'b1, 1'b1);
    frame(17'h00003, 16, 1'b1, 12'h000);
    check_flags("t3_trail", 12'hABC, 1'b1, 1'b1);

    @(negedge CLK40) CLR_RX_DONE = 1'b1;
    @(negedge CLK40) CLR_RX_DONE = 1'b0;
    check_flags("clr", 12'hABC, 1'b0, 1'b0);

    // CLR_RX_DONE coincident with the DONE cycle of code 12'h001
    clr_seen = 1'b0;
    fork
      frame(17'h00002, 16, 1'b0, 12'h001);
      begin
        for (int k = 0; k < 2000 && !clr_seen; k++) begin
          @(negedge CLK40);
          if (RX_VALID === 1'b1) begin
            clr_seen = 1'b1;
            CLR_RX_DONE = 1'b1;
            @(negedge CLK40) CLR_RX_DONE = 1'b0;
          end
        end
      end
    join
    check("t4_clr_aligned", 32'(clr_seen), 32'd1);
    check_flags("t4", 12'h001, 1'b1, 1'b0);

    // reset after 8 bits of 12'hFFF (stream 16'h1FFE)
    DAC_ENB = 1'b1;
    repeat (10) @(posedge CLK40);
    send_bits(17'h0001F, 8);
    RST_N = 1'b0;
    DAC_ENB = 1'b0;
    SDATA = 1'b0;
    repeat (3) @(posedge CLK40);
    check_reset_outputs("t5_in_reset");
    @(negedge CLK40) RST_N = 1'b1;
    repeat (10) @(posedge CLK40);
    check_reset_outputs("t5_after_release");
    frame(17'h00246, 16, 1'b0, 12'h123);
    check_flags("t5", 12'h123, 1'b1, 1'b0);

    // SCLK stops after 5 bits with DAC_ENB held high
    DAC_ENB = 1'b1;
    repeat (10) @(posedge CLK40);
`ifdef CDAC_RX_TIMEOUT_EN
    push(1'b1, 12'h000);
    send_bits(17'h00002, 5);
    repeat (300) @(posedge CLK40);
    #1;
    check("t6_state_after_timeout", 32'(RX_STATE), 32'd0);
    check("t6_ferr_after_timeout", 32'(FRAME_ERR), 32'd1);
    wait_drain();
    DAC_ENB = 1'b0;
    repeat (50) @(posedge CLK40);
    check_flags("t6_after_fall", 12'h123, 1'b1, 1'b1);
`else
    send_bits(17'h00002, 5);
    repeat (300) @(posedge CLK40);
    #1;
    check("t6_state_held", 32'(RX_STATE), 32'd1);
    check("t6_ferr_held", 32'(FRAME_ERR), 32'd0);
    push(1'b1, 12'h000);
    DAC_ENB = 1'b0;
    wait_drain();
    check_flags("t6_after_fall", 12'h123, 1'b1, 1'b1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
